// File: rtl/alu.sv
// Two-operand ALU: add/subtract, bit-gated AND, XOR and logical shifts.
// out_val is purely combinational; out_q/carry_q/zero_q register it one cycle later.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       alu_op,
    input  logic             sub,
    output logic [WIDTH-1:0] out_val,
    output logic [WIDTH-1:0] out_q,
    output logic             carry_q,
    output logic             zero_q
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shl_s;
    logic [WIDTH:0] shr_s;
    logic           carry_d;
    logic           zero_d;

    // Widened arithmetic and shifts: the extra bit carries the carry/borrow or the last bit shifted out.
    always_comb begin
        sum_s = {WIDTH+1{1'b0}};
        if (sub) begin
            sum_s = {1'b0, in1} - {1'b0, in2};
        end else begin
            sum_s = {1'b0, in1} + {1'b0, in2};
        end
        shl_s = {1'b0, in1} << in2;
        shr_s = {in1, 1'b0} >> in2;
    end

    // Result and carry selection by operation.
    always_comb begin
        out_val = {WIDTH{1'b0}};
        carry_d = 1'b0;
        case (alu_op)
            2'b00: begin
                out_val = sum_s[WIDTH-1:0];
                carry_d = sum_s[WIDTH];
            end
            2'b01: begin
                out_val = in1 & {WIDTH{in2[0]}};
                carry_d = 1'b0;
            end
            2'b10: begin
                out_val = in1 ^ in2;
                carry_d = 1'b0;
            end
            2'b11: begin
                if (sub) begin
                    out_val = shr_s[WIDTH:1];
                    carry_d = shr_s[0];
                end else begin
                    out_val = shl_s[WIDTH-1:0];
                    carry_d = shl_s[WIDTH];
                end
            end
            default: begin
                out_val = {WIDTH{1'b0}};
                carry_d = 1'b0;
            end
        endcase
    end

    assign zero_d = (out_val == {WIDTH{1'b0}});

    // Output registers; reset clears them immediately and holds them clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            out_q   <= out_val;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, random vectors against a
// reference model, and hand-written reset sequences, with a result scoreboard.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [1:0] alu_op;
    logic       sub;
    logic [7:0] out_val;
    logic [7:0] out_q;
    logic       carry_q;
    logic       zero_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] op;
        logic       sb;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] val;
        logic       c;
        logic       z;
    } vec_t;

    typedef struct {
        logic [7:0] val;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (in1),
        .in2     (in2),
        .alu_op  (alu_op),
        .sub     (sub),
        .out_val (out_val),
        .out_q   (out_q),
        .carry_q (carry_q),
        .zero_q  (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: integer arithmetic and bit-index carry selection.
    function automatic exp_t model(input logic [1:0] op, input logic sb,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        int   ia, ib, s, n;
        ia = int'(a);
        ib = int'(b);
        r.val = 8'h00;
        r.c   = 1'b0;
        case (op)
            2'b00: begin
                if (!sb) begin
                    s = ia + ib;
                    r.val = 8'(s % 256);
                    r.c   = (s > 255);
                end else begin
                    s = ia - ib;
                    if (s < 0) s = s + 256;
                    r.val = 8'(s);
                    r.c   = (ia < ib);
                end
            end
            2'b01: r.val = b[0] ? a : 8'h00;
            2'b10: r.val = a ^ b;
            default: begin
                n = ib;
                if (n >= 8) r.val = 8'h00;
                else if (!sb) r.val = 8'((ia * (1 << n)) % 256);
                else r.val = 8'(ia / (1 << n));
                if (n >= 1 && n <= 8) r.c = sb ? a[n-1] : a[8-n];
            end
        endcase
        r.z = (r.val == 8'h00);
        return r;
    endfunction

    task automatic drive(input logic [1:0] op, input logic sb,
                         input logic [7:0] a, input logic [7:0] b);
        alu_op = op;
        sub    = sb;
        in1    = a;
        in2    = b;
    endtask

    task automatic apply(input string name, input logic [1:0] op, input logic sb,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e_val, input logic e_c, input logic e_z);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(op, sb, a, b);
        #1;
        check({name, " out_val"}, out_val, e_val);
        e.val = e_val;
        e.c   = e_c;
        e.z   = e_z;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", name);
        end else begin
            got = sb_q.pop_front();
            check({name, " out_q"},   out_q,          got.val);
            check({name, " carry_q"}, {7'd0, carry_q}, {7'd0, got.c});
            check({name, " zero_q"},  {7'd0, zero_q},  {7'd0, got.z});
        end
    endtask

    initial begin
        exp_t m;
        logic [1:0] rop;
        logic       rsb;
        logic [7:0] ra, rb;

        vecs[0]  = '{2'b00, 1'b0, 8'h0A, 8'h0F, 8'h19, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 1'b1, 8'h14, 8'h05, 8'h0F, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 1'b0, 8'hAA, 8'h01, 8'hAA, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 8'hAA, 8'hFE, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 1'b0, 8'hF0, 8'hAA, 8'h5A, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 1'b1, 8'hF0, 8'hAA, 8'h5A, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 1'b0, 8'h03, 8'h02, 8'h0C, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 1'b1, 8'h0C, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 1'b0, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{2'b11, 1'b1, 8'hFF, 8'h08, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{2'b00, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{2'b11, 1'b0, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0};
        vecs[13] = '{2'b11, 1'b1, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0};
        vecs[14] = '{2'b11, 1'b0, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0};
        vecs[15] = '{2'b11, 1'b1, 8'hFF, 8'h09, 8'h00, 1'b0, 1'b1};
        vecs[16] = '{2'b00, 1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
        vecs[17] = '{2'b11, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};

        // Reset state, held across a clock edge, with out_val still live.
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 8'h0A, 8'h0F);
        #1;
        check("reset out_q",   out_q,           8'h00);
        check("reset carry_q", {7'd0, carry_q}, 8'h00);
        check("reset zero_q",  {7'd0, zero_q},  8'h00);
        check("reset out_val live", out_val,    8'h19);
        @(posedge clk);
        #1;
        check("reset hold out_q",  out_q,          8'h00);
        check("reset hold zero_q", {7'd0, zero_q}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release loads normally.
        @(posedge clk);
        #1;
        check("post-reset first edge out_q", out_q, 8'h19);

        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].sb, vecs[i].a, vecs[i].b,
                  vecs[i].val, vecs[i].c, vecs[i].z);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rsb = 1'($urandom_range(0, 1));
            ra  = 8'($urandom_range(0, 255));
            rb  = (rop == 2'b11) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
            m = model(rop, rsb, ra, rb);
            apply($sformatf("rand%0d", i), rop, rsb, ra, rb, m.val, m.c, m.z);
        end

        // Mid-cycle reset clears registers at once and overrides the pending edge.
        apply("pre-reset", 2'b00, 1'b0, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset out_q",   out_q,           8'h00);
        check("mid reset carry_q", {7'd0, carry_q}, 8'h00);
        drive(2'b00, 1'b0, 8'h03, 8'h04);
        #1;
        check("mid reset out_val live", out_val, 8'h07);
        @(posedge clk);
        #1;
        check("reset overrides edge out_q",   out_q,           8'h00);
        check("reset overrides edge carry_q", {7'd0, carry_q}, 8'h00);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release loads out_q",  out_q,          8'h07);
        check("release loads zero_q", {7'd0, zero_q}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
